// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that adds two WIDTH-bit operands through one shared 4-bit adder slice,
// one nibble per clock, LSB nibble first. Define NIBBLE_SERIAL_SUB_EN to add a subtract mode.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       step;

    // Subtraction is a + ~b + 1, so the inversion and forced carry are applied at capture time.
`ifdef NIBBLE_SERIAL_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : ci;
`else
    assign b_in = b;
    assign c_in = ci;
`endif

    // NOTE: every signal assigned in always_comb gets a value on every path; a missing
    // default here would infer a latch instead of a plain mux.
    always_comb begin
        a_nib = a_r[{cnt, 2'b00} +: 4];
        b_nib = b_r[{cnt, 2'b00} +: 4];
        step  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    end

    // NOTE: all state updates use non-blocking assignments so each register samples the
    // pre-edge values of the others, whatever order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b_in;
                        carry <= c_in;
                        s     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[{cnt, 2'b00} +: 4] <= step[3:0];
                    carry                <= step[4];
                    if (cnt == LAST) begin
                        // Counter holds on the final step so a single-nibble build keeps cnt at 0.
                        co    <= step[4];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
